stream_mux_rr: RTL

- Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes.
- Arbitrates among input channels and registers the winner into a single output stage, tagging each word with its source channel index.
- Arbitration is round-robin or fixed-priority, selected at run time by `mode`.
- Sits between several producer streams and one shared consumer; it replaces hand-built 4:1 gate muxes where the select is decided by traffic rather than by an external `sel`.

---
 rtl/stream_mux_pkg.sv | 10 +
 rtl/stream_mux_rr_arbiter.sv | 52 +++++
 rtl/stream_mux_rr.sv | 92 +++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types for the round-robin / fixed-priority stream multiplexer.
package stream_mux_pkg;

  // Arbitration policy, selected at run time by the mode input.
  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mux_mode_t;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: finds the first requester at or after a start
// position (wrapping), using a double-width masked priority search.
// In fixed mode the start position is forced to 0, so the lowest index wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)   // derived; leave at default
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  mux_mode_t        mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] w_start;
  logic [2*N-1:0]   w_req2;
  logic [2*N-1:0]   w_mask2;
  logic [2*N-1:0]   w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_hit;

  assign w_start = (mode == MODE_FIXED) ? {IDX_W{1'b0}} : ptr;
  assign w_req2  = {req, req};
  assign w_cand  = w_req2 & w_mask2;

  // Keep only lower-half positions at or above the start; the upper copy
  // is always eligible and supplies the wrapped-around requesters.
  always_comb begin
    w_mask2 = {(2*N){1'b0}};
    for (int j = 0; j < 2*N; j++) begin
      w_mask2[j] = (j >= int'(w_start));
    end
  end

  // Lowest set candidate bit wins; its position modulo N is the channel.
  always_comb begin
    w_found = 1'b0;
    w_hit   = {IDX_W{1'b0}};
    for (int j = 0; j < 2*N; j++) begin
      w_hit   = (!w_found && w_cand[j]) ? IDX_W'(j % N) : w_hit;
      w_found = w_found | w_cand[j];
    end
  end

  assign any   = w_found;
  assign idx   = w_hit;
  assign grant = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_hit) : {N{1'b0}};

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Each output word carries the index of the channel it came from.
// Note for integrators: in_ready depends combinationally on out_ready.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CH_W = $clog2(N_CH)   // derived; leave at default
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [CH_W-1:0]     out_ch,
  input  logic                out_ready
);

  logic              r_out_valid;
  logic [W-1:0]      r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;

  mux_mode_t         w_mode;
  logic [N_CH-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_load_en;
  logic              w_xfer;
  logic [W-1:0]      w_sel_data;
  logic [CH_W-1:0]   w_ptr_next;

  assign w_mode = mux_mode_t'(mode);

  rr_arbiter #(
    .N     (N_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .mode  (w_mode),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Output stage can take a word when empty or being drained this cycle.
  assign w_load_en  = ~r_out_valid | out_ready;
  assign in_ready   = w_load_en ? w_grant : {N_CH{1'b0}};
  assign w_xfer     = w_load_en & w_any;
  assign w_sel_data = in_data[w_idx*W +: W];

  // Explicit wrap so non-power-of-two channel counts return to 0.
  assign w_ptr_next = (w_idx == CH_W'(N_CH-1)) ? {CH_W{1'b0}} : (w_idx + {{(CH_W-1){1'b0}}, 1'b1});

  // Output register: load on transfer, clear valid on a drain with no load, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {W{1'b0}};
      r_out_ch    <= {CH_W{1'b0}};
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Round-robin pointer: advance past the winner in RR mode, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= {CH_W{1'b0}};
    end else if (w_xfer && (w_mode == MODE_RR)) begin
      r_ptr <= w_ptr_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule : stream_mux_rr
